// File: rtl/clk_en_scheduler_if.sv
// Handshake/bus bundle between the clock-enable scheduler and its controller.
// The slave side is the scheduler; the master side drives start/stop/config.
interface clk_en_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 8
);
    logic                    start;
    logic                    stop;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [NUM_CH*CNT_W-1:0] cfg_div;
    logic [NUM_CH-1:0]       ch_clk;
    logic [NUM_CH-1:0]       ch_rise;
    logic                    all_rise;
    logic                    running;

    modport master (
        output start, stop, cfg_valid, cfg_div,
        input  cfg_ready, ch_clk, ch_rise, all_rise, running
    );

    modport slave (
        input  start, stop, cfg_valid, cfg_div,
        output cfg_ready, ch_clk, ch_rise, all_rise, running
    );
endinterface

// File: rtl/clk_en_scheduler.sv
// Bank of edge-aligned divided clock-enable channels; start, stop and ratio
// changes all take effect on channel-0 period boundaries.
module clk_en_scheduler #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 8
) (
    input  logic    clk,
    input  logic    rst,
    clk_en_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, SWITCH, STOPPING} state_e;
    typedef logic [NUM_CH-1:0][CNT_W-1:0] ratio_t;

    state_e                  state_q, state_d;
    ratio_t                  div_q, div_d, cnt_q, cnt_d, pend_q, pend_d;
    ratio_t                  cnt_adv, cfg_clamp, cfg_raw;
    logic                    pend_vld_q, pend_vld_d;
    logic [NUM_CH-1:0]       ch_clk_q, ch_clk_d, ch_rise_q, ch_rise_d;
    logic [NUM_CH-1:0][CNT_W:0] high_d;
    logic                    all_rise_q, running_q, cfg_ready_q;
    logic                    cfg_fire, ch0_last, active_d;

    assign cfg_raw  = bus.cfg_div;
    assign cfg_fire = bus.cfg_valid && cfg_ready_q;
    assign ch0_last = (cnt_q[0] == div_q[0] - CNT_W'(1));

    // Outputs are registered from next-state values so they line up with cnt_q.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign cfg_clamp[i] = (cfg_raw[i] < CNT_W'(2)) ? CNT_W'(2) : cfg_raw[i];
        assign cnt_adv[i]   = (cnt_q[i] == div_q[i] - CNT_W'(1)) ? '0 : cnt_q[i] + CNT_W'(1);
        // Extra width keeps (div+1)>>1 exact at div = 2^CNT_W-1.
        assign high_d[i]    = ({1'b0, div_d[i]} + (CNT_W+1)'(1)) >> 1;
        assign ch_clk_d[i]  = active_d && ({1'b0, cnt_d[i]} < high_d[i]);
        assign ch_rise_d[i] = active_d && (cnt_d[i] == '0);
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cnt_d      = cnt_adv;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cfg_fire)
                    div_d = cfg_clamp;
                if (bus.start && !bus.stop)
                    state_d = RUN;
            end
            RUN: begin
                // A ratio accepted together with stop is held and committed at stop.
                if (cfg_fire) begin
                    pend_d     = cfg_clamp;
                    pend_vld_d = 1'b1;
                end
                if (bus.stop)
                    state_d = STOPPING;
                else if (cfg_fire)
                    state_d = SWITCH;
            end
            SWITCH: begin
                if (bus.stop) begin
                    state_d = STOPPING;
                end else if (ch0_last) begin
                    div_d      = pend_q;
                    pend_vld_d = 1'b0;
                    cnt_d      = '0;
                    state_d    = RUN;
                end
            end
            STOPPING: begin
                if (ch0_last) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (pend_vld_q) begin
                        div_d      = pend_q;
                        pend_vld_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            div_q       <= {NUM_CH{CNT_W'(2)}};
            cnt_q       <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            ch_clk_q    <= '0;
            ch_rise_q   <= '0;
            all_rise_q  <= 1'b0;
            running_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            ch_clk_q    <= ch_clk_d;
            ch_rise_q   <= ch_rise_d;
            all_rise_q  <= &ch_rise_d;
            running_q   <= active_d;
            cfg_ready_q <= (state_d == IDLE) || (state_d == RUN);
        end
    end

    assign bus.ch_clk    = ch_clk_q;
    assign bus.ch_rise   = ch_rise_q;
    assign bus.all_rise  = all_rise_q;
    assign bus.running   = running_q;
    assign bus.cfg_ready = cfg_ready_q;
endmodule

// File: tb/tb_clk_en_scheduler.sv
// Randomized bench for clk_en_scheduler: directed scenarios followed by random
// traffic, checked every cycle against a time-since-alignment reference model.
module tb_clk_en_scheduler;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    logic rst;

    clk_en_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    clk_en_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference: mode, cycles elapsed since channels were last aligned, ratios.
    int ms;  // 0 idle, 1 run, 2 switch, 3 stopping
    int mt;
    int mpv;
    int mdiv[NUM_CH];
    int mpend[NUM_CH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp2(input int x);
        return (x < 2) ? 2 : x;
    endfunction

    function automatic int rdiv();
        if ($urandom_range(0, 19) == 0)
            return int'($urandom_range(250, 255));
        return int'($urandom_range(0, 9));
    endfunction

    task automatic model_reset();
        ms  = 0;
        mt  = 0;
        mpv = 0;
        foreach (mdiv[i]) begin
            mdiv[i]  = 2;
            mpend[i] = 0;
        end
    endtask

    task automatic check_outputs();
        logic [NUM_CH-1:0] eclk, erise;
        int c;
        eclk  = '0;
        erise = '0;
        if (ms != 0) begin
            for (int i = 0; i < NUM_CH; i++) begin
                c        = mt % mdiv[i];
                eclk[i]  = (c < (mdiv[i] + 1) / 2);
                erise[i] = (c == 0);
            end
        end
        chk("ch_clk",    32'(bus.ch_clk),    32'(eclk));
        chk("ch_rise",   32'(bus.ch_rise),   32'(erise));
        chk("all_rise",  32'(bus.all_rise),  32'(&erise));
        chk("running",   32'(bus.running),   32'(ms != 0));
        chk("cfg_ready", 32'(bus.cfg_ready), 32'(ms <= 1));
    endtask

    // One cycle: check current outputs, drive inputs for the next edge, advance model.
    task automatic cyc(input bit r, input bit s, input bit p, input bit v,
                       input int d0, input int d1, input int d2);
        int  dv[NUM_CH];
        bit  fire, last0;
        logic [CNT_W-1:0] b0, b1, b2;
        @(negedge clk);
        check_outputs();
        b0 = d0[CNT_W-1:0];
        b1 = d1[CNT_W-1:0];
        b2 = d2[CNT_W-1:0];
        rst           = r;
        bus.start     = s;
        bus.stop      = p;
        bus.cfg_valid = v;
        bus.cfg_div   = {b2, b1, b0};
        dv[0] = int'(b0);
        dv[1] = int'(b1);
        dv[2] = int'(b2);
        if (r) begin
            model_reset();
            return;
        end
        fire  = v && (ms <= 1);
        last0 = ((mt % mdiv[0]) == mdiv[0] - 1);
        case (ms)
            0: begin
                if (fire)
                    foreach (dv[i]) mdiv[i] = clamp2(dv[i]);
                if (s && !p) begin
                    ms = 1;
                    mt = 0;
                end
            end
            1: begin
                if (fire) begin
                    foreach (dv[i]) mpend[i] = clamp2(dv[i]);
                    mpv = 1;
                end
                mt++;
                if (p)
                    ms = 3;
                else if (fire)
                    ms = 2;
            end
            2: begin
                if (p) begin
                    ms = 3;
                    mt++;
                end else if (last0) begin
                    mdiv = mpend;
                    mpv  = 0;
                    mt   = 0;
                    ms   = 1;
                end else begin
                    mt++;
                end
            end
            default: begin
                if (last0) begin
                    ms = 0;
                    mt = 0;
                    if (mpv != 0) begin
                        mdiv = mpend;
                        mpv  = 0;
                    end
                end else begin
                    mt++;
                end
            end
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic stop_and_drain();
        cyc(0, 0, 1, 0, 0, 0, 0);
        idle(20);
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = '0;
        model_reset();
        @(posedge clk);

        cyc(1, 0, 0, 0, 0, 0, 0);
        // {2,4,8} from a start pulse
        cyc(0, 0, 0, 1, 2, 4, 8);
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(20);
        // {3,5,1}: odd ratios and a clamped channel
        stop_and_drain();
        cyc(0, 0, 0, 1, 3, 5, 1);
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(20);
        // reconfigure {4,4,4} -> {2,6,8} at cnt0=1
        stop_and_drain();
        cyc(0, 0, 0, 1, 4, 4, 4);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 2, 6, 8);
        idle(20);
        // stop at cnt0=0 with div0=8, then restart
        stop_and_drain();
        cyc(0, 0, 0, 1, 8, 3, 5);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0);
        idle(12);
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(10);
        // reset in the middle of a switch; pending must be dropped
        stop_and_drain();
        cyc(0, 0, 0, 1, 4, 4, 4);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 2, 6, 8);
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(10);
        // start with stop in IDLE is ignored; start alone then runs
        stop_and_drain();
        cyc(0, 1, 1, 0, 0, 0, 0);
        idle(2);
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(6);
        // stop and cfg together in RUN
        cyc(0, 0, 1, 1, 5, 5, 5);
        idle(10);
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(12);
        // maximum ratio wraps exactly
        stop_and_drain();
        cyc(0, 0, 0, 1, 255, 254, 2);
        cyc(0, 1, 0, 0, 0, 0, 0);
        idle(520);
        stop_and_drain();
        idle(260);

        for (int k = 0; k < 3000; k++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0,
                rdiv(), rdiv(), rdiv());
        end
        @(negedge clk);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
